// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe from clk/CLK_DIV, h/v counters, valid and active-low syncs; all outputs registered, 0-cycle counter-to-pixel latency.
// Free-running, no backpressure. Optional frame counter under VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pclk_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]       HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]       VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             frame_wrap;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Next coordinates; every registered flag is decoded from these so it lines up with the counters.
  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
  end

  assign frame_wrap = (h_nxt == 10'd0) && (v_nxt == 10'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      pclk_en     <= 1'b0;
      valid       <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (tick) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      pclk_en     <= 1'b1;
      valid       <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      hsync       <= !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
      vsync       <= !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
      line_start  <= (h_nxt == 10'd0);
      frame_start <= frame_wrap;
    end else begin
      pclk_en     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Counts on the same edge frame_start rises, so it reads 1 throughout the first frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 8'd0;
    end else if (tick && frame_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations checked every clk against a closed-form raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pclk_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_cnt;
  } vis_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // A: default 640x480, CLK_DIV=4. B: tiny raster, CLK_DIV=4. C: default H, short V, CLK_DIV=2.
  logic       a_pe, a_val, a_hs, a_vs, a_ls, a_fs;
  logic [9:0] a_h, a_v;
  logic [7:0] a_fc;
  logic       b_pe, b_val, b_hs, b_vs, b_ls, b_fs;
  logic [9:0] b_h, b_v;
  logic [7:0] b_fc;
  logic       c_pe, c_val, c_hs, c_vs, c_ls, c_fs;
  logic [9:0] c_h, c_v;
  logic [7:0] c_fc;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .pclk_en(a_pe), .h_cnt(a_h), .v_cnt(a_v), .valid(a_val),
    .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc));

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .pclk_en(b_pe), .h_cnt(b_h), .v_cnt(b_v), .valid(b_val),
    .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc));

  vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .pclk_en(c_pe), .h_cnt(c_h), .v_cnt(c_v), .valid(c_val),
    .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc));

  vis_t obs_a, obs_b, obs_c;
  assign obs_a = {a_pe, a_h, a_v, a_val, a_hs, a_vs, a_ls, a_fs, a_fc};
  assign obs_b = {b_pe, b_h, b_v, b_val, b_hs, b_vs, b_ls, b_fs, b_fc};
  assign obs_c = {c_pe, c_h, c_v, c_val, c_hs, c_vs, c_ls, c_fs, c_fc};

  // Expected outputs k rising edges after reset release: pixel p = k/cd - 1 is shown from edge (p+1)*cd on.
  function automatic vis_t model(input int k, input int cd,
                                 input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb);
    vis_t e;
    int ht, vt, p, h, v, frames;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (k < cd) begin
      e = '{pclk_en: 1'b0, h_cnt: 10'(ht - 1), v_cnt: 10'(vt - 1), valid: 1'b0, hsync: 1'b1,
            vsync: 1'b1, line_start: 1'b0, frame_start: 1'b0, frame_cnt: 8'd0};
    end else begin
      p      = k / cd - 1;
      h      = p % ht;
      v      = (p / ht) % vt;
      frames = p / (ht * vt) + 1;
      e.pclk_en     = (k % cd == 0);
      e.h_cnt       = 10'(h);
      e.v_cnt       = 10'(v);
      e.valid       = (h < ha) && (v < va);
      e.hsync       = !((h >= ha + hf) && (h < ha + hf + hsw));
      e.vsync       = !((v >= va + vf) && (v < va + vf + vsw));
      e.line_start  = e.pclk_en && (h == 0);
      e.frame_start = e.pclk_en && (h == 0) && (v == 0);
`ifdef VGA_FRAME_CNT_EN
      e.frame_cnt   = 8'(frames % 256);
`else
      e.frame_cnt   = 8'd0;
`endif
    end
    return e;
  endfunction

  task automatic chk(input string tag, input string field, input int k,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) passes++;
    else begin
      fails++;
      $error("FAIL %s.%s k=%0d observed=%0h expected=%0h", tag, field, k, got, want);
    end
  endtask

  task automatic cmp(input string tag, input int k, input vis_t o, input vis_t e);
    chk(tag, "pclk_en",     k, 32'(o.pclk_en),     32'(e.pclk_en));
    chk(tag, "h_cnt",       k, 32'(o.h_cnt),       32'(e.h_cnt));
    chk(tag, "v_cnt",       k, 32'(o.v_cnt),       32'(e.v_cnt));
    chk(tag, "valid",       k, 32'(o.valid),       32'(e.valid));
    chk(tag, "hsync",       k, 32'(o.hsync),       32'(e.hsync));
    chk(tag, "vsync",       k, 32'(o.vsync),       32'(e.vsync));
    chk(tag, "line_start",  k, 32'(o.line_start),  32'(e.line_start));
    chk(tag, "frame_start", k, 32'(o.frame_start), 32'(e.frame_start));
    chk(tag, "frame_cnt",   k, 32'(o.frame_cnt),   32'(e.frame_cnt));
  endtask

  task automatic check_all(input int k);
    cmp("a", k, obs_a, model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33));
    cmp("b", k, obs_b, model(k, 4, 16, 2, 3, 2, 6, 1, 2, 1));
    cmp("c", k, obs_c, model(k, 2, 640, 16, 96, 48, 4, 1, 2, 1));
  endtask

  task automatic run_segment(input int cycles);
    int k;
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      k++;
      #1;
      check_all(k);
    end
  endtask

  // Asynchronous mid-cycle reset: outputs must snap to reset values before the next edge.
  task automatic async_reset(input int hold);
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    check_all(0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_all(0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all(0);

    // Covers several default lines, more than one C frame and ~15 B frames.
    run_segment(14000);

    for (int s = 0; s < 3; s++) begin
      async_reset(int'($urandom_range(1, 5)));
      run_segment(int'($urandom_range(1500, 6000)));
    end

    // Reset landing right after a random short run, i.e. mid-line before any wrap.
    async_reset(2);
    run_segment(int'($urandom_range(5, 40)));
    async_reset(1);
    run_segment(3300);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
